pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator, the next generation of the team's fixed 4×8-bit motor/relay PWM. Drives `NCH` outputs from one shared period counter with a programmable period, clock prescaler, per-channel enable and polarity, and glitch-free shadowed duty updates applied only at period boundaries. Sits behind the bus wrapper, which supplies packed duty words and configuration strobes. Outputs feed the motor/relay drivers.

## Interface
- `NCH`, 4: number of PWM channels (1..16).
- `CW`, 8: counter/duty width in bits (4..16).
- `PSW`, 8: prescaler width in bits.
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_we` input 1: write strobe for `cfg_period`/`cfg_prescale` into shadow.
- `cfg_period` input CW: counter top value.
- `cfg_prescale` input PSW: clock divide minus one.
- `duty_we` input 1: write strobe for all duty shadows.
- `duty_in` input NCH*CW: packed duties; channel i = `duty_in[i*CW +: CW]`.
- `ch_en` input NCH: per-channel enable, sampled every cycle.
- `invert` input NCH: per-channel output polarity, sampled every cycle.
- `pwm_o` output NCH: PWM outputs, registered.
- `period_tick` output 1: one-cycle pulse on each period boundary (shadow load).

## Operation
- Prescaler `ps_cnt` counts 0..`prescale_act`. `tick` is asserted in the cycle where `ps_cnt == prescale_act`, and `ps_cnt` returns to 0 on that cycle. With `prescale_act = 0`, `tick` is asserted every cycle.
- Edge mode: the counter `cnt` advances on `tick`: 0,1,…,`period_act`, then wraps to 0.
- Boundary: the `tick` cycle in which `cnt` goes to 0. `period_tick` is asserted in this cycle.
- At each boundary, the active registers (`period_act`, `prescale_act`, all `duty_act[i]`) are loaded from their shadows.
- Shadows:
  - `cfg_we` and `duty_we` write their shadows at any time.
  - A write in the same cycle as a boundary bypasses the shadow: the newly written value is what gets loaded.
  - Repeated writes within one period: the last write wins.
- Raw compare: `raw[i] = (cnt < duty_act[i])`, unsigned CW-bit compare.
  - `duty_act = 0` gives constant low.
  - `duty_act > period_act` gives constant high (100%).
- Output: `pwm_o[i] <= ch_en[i] ? raw[i] ^ invert[i] : invert[i]`. A disabled channel drives its inactive level immediately, without waiting for a boundary.
- `period_act = 0`: `cnt` stays 0; a boundary occurs on every `tick`.
- Reset (asynchronous, any time including mid-period):
  - `ps_cnt`, `cnt`, all shadows and actives are cleared to 0.
  - `pwm_o` = 0, `period_tick` = 0.
  - The first boundary occurs on the first `tick` after reset release.

## Timing
- `pwm_o` lags `cnt` by one clock (registered compare).
- Edge-mode period length: (`period_act`+1)·(`prescale_act`+1) clocks.
- Duty high time: `duty_act`·(`prescale_act`+1) clocks, for `duty_act` ≤ `period_act`+1.
- Shadow-to-output latency: a write becomes visible at the next boundary, and appears on `pwm_o` one clock later.
- `ch_en`/`invert` changes reach `pwm_o` one clock later, regardless of period position.
- `period_tick` is high for exactly one clock per period. It is never asserted while `rst` is high.

## Configuration
- `PWM_CENTER_EN`: when defined, adds input `center` (1 bit), which is sampled only at boundaries.
  - With `center = 1`, `cnt` counts up 0…`period_act`, then down `period_act-1`…1, then the boundary returns it to 0.
  - Period = 2·`period_act`·(`prescale_act`+1) clocks. Pulses are symmetric about `cnt = period_act`.
  - `period_act = 0` behaves as in edge mode.
- When undefined: the port is absent and behaviour is edge mode only.

## Test plan
- Reset: assert `rst` mid-period with `duty = 8'h80` → `pwm_o` = 0 and `period_tick` = 0 immediately; after release with no writes → all outputs stay 0.
- Edge duty: NCH=4, CW=8, period=9, prescale=0, duties {0,3,10,255}, all enabled → per 10-clock period, high times are 0, 3, 10, 10 clocks; `period_tick` every 10 clocks.
- Prescaler and shadow: prescale=2, period=3, duty 2→1 written mid-period → current period keeps 6 high of 12 clocks; the next period is 3 high of 12.
- Boundary collision: `duty_we` (duty=5) in the same cycle as `period_tick` → new duty applies in the period starting at that boundary.
- Enable/invert: `ch_en[1]` dropped mid-pulse with `invert[1]=1` → `pwm_o[1]` = 1 on the next clock; raising `ch_en[1]` resumes tracking the compare on the next clock.
- `PWM_CENTER_EN`: `center`=1, period=4, prescale=0, duty=2 → 8-clock period; high at `cnt` 0,1 (rise) and 1 (fall) → 3 clocks high, symmetric.

Source files
------------

// File: rtl/pwm_multi_if.sv
// Bus-side bundle for pwm_multi: shadow write strobes, per-channel enable/polarity and PWM outputs.
// When PWM_CENTER_EN is defined the bundle also carries the center-aligned mode select.
interface pwm_multi_if #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int PSW = 8
);
  logic              cfg_we;
  logic [CW-1:0]     cfg_period;
  logic [PSW-1:0]    cfg_prescale;
  logic              duty_we;
  logic [NCH*CW-1:0] duty_in;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    invert;
  logic [NCH-1:0]    pwm_o;
  logic              period_tick;
`ifdef PWM_CENTER_EN
  logic              center;
`endif

  modport master (
`ifdef PWM_CENTER_EN
    output center,
`endif
    output cfg_we, cfg_period, cfg_prescale,
    output duty_we, duty_in, ch_en, invert,
    input  pwm_o, period_tick
  );

  modport slave (
`ifdef PWM_CENTER_EN
    input  center,
`endif
    input  cfg_we, cfg_period, cfg_prescale,
    input  duty_we, duty_in, ch_en, invert,
    output pwm_o, period_tick
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, shadowed period/prescale/duty loaded at period
// boundaries, per-channel enable and polarity. Define PWM_CENTER_EN for center-aligned counting.
module pwm_multi #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int PSW = 8
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);

  logic [PSW-1:0]    ps_cnt_q, ps_cnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     period_sh_q, period_sh_d;
  logic [CW-1:0]     period_act_q, period_act_d;
  logic [PSW-1:0]    prescale_sh_q, prescale_sh_d;
  logic [PSW-1:0]    prescale_act_q, prescale_act_d;
  logic [NCH*CW-1:0] duty_sh_q, duty_sh_d;
  logic [NCH*CW-1:0] duty_act_q, duty_act_d;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic [NCH-1:0]    raw;
  logic              tick;
  logic              boundary;
`ifdef PWM_CENTER_EN
  logic              center_q, center_d;
  logic              down_q, down_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned (no latch).
  always_comb begin
    ps_cnt_d = ps_cnt_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    tick     = (ps_cnt_q == prescale_act_q);
`ifdef PWM_CENTER_EN
    down_d   = down_q;
`endif
    if (tick) begin
      ps_cnt_d = '0;
`ifdef PWM_CENTER_EN
      // Center mode: up to the top, then down to 1; the boundary closes the triangle back to 0.
      if (center_q && (period_act_q > CW'(1))) begin
        if (!down_q) begin
          if (cnt_q >= period_act_q) begin
            down_d = 1'b1;
            cnt_d  = cnt_q - CW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q <= CW'(1)) begin
          boundary = 1'b1;
          down_d   = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end else
`endif
      if (cnt_q >= period_act_q) begin
        boundary = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      ps_cnt_d = ps_cnt_q + PSW'(1);
    end
  end

  // Shadows take writes at any time; a write landing on a boundary goes straight to the actives.
  always_comb begin
    period_sh_d    = bus.cfg_we  ? bus.cfg_period   : period_sh_q;
    prescale_sh_d  = bus.cfg_we  ? bus.cfg_prescale : prescale_sh_q;
    duty_sh_d      = bus.duty_we ? bus.duty_in      : duty_sh_q;
    period_act_d   = boundary ? period_sh_d   : period_act_q;
    prescale_act_d = boundary ? prescale_sh_d : prescale_act_q;
    duty_act_d     = boundary ? duty_sh_d     : duty_act_q;
`ifdef PWM_CENTER_EN
    center_d       = boundary ? bus.center    : center_q;
`endif
  end

  always_comb begin
    raw   = '0;
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      raw[i]   = (cnt_q < duty_act_q[i*CW +: CW]);
      pwm_d[i] = bus.ch_en[i] ? (raw[i] ^ bus.invert[i]) : bus.invert[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt_q       <= '0;
      cnt_q          <= '0;
      period_sh_q    <= '0;
      period_act_q   <= '0;
      prescale_sh_q  <= '0;
      prescale_act_q <= '0;
      // NOTE: the duty banks are reset too, so no stale duty can reach a driver after reset.
      duty_sh_q      <= '0;
      duty_act_q     <= '0;
      pwm_q          <= '0;
`ifdef PWM_CENTER_EN
      center_q       <= 1'b0;
      down_q         <= 1'b0;
`endif
    end else begin
      ps_cnt_q       <= ps_cnt_d;
      cnt_q          <= cnt_d;
      period_sh_q    <= period_sh_d;
      period_act_q   <= period_act_d;
      prescale_sh_q  <= prescale_sh_d;
      prescale_act_q <= prescale_act_d;
      duty_sh_q      <= duty_sh_d;
      duty_act_q     <= duty_act_d;
      pwm_q          <= pwm_d;
`ifdef PWM_CENTER_EN
      center_q       <= center_d;
      down_q         <= down_d;
`endif
    end
  end

  assign bus.pwm_o = pwm_q;
  // Held-in-reset state looks like a boundary every cycle; keep the strobe quiet until release.
  assign bus.period_tick = boundary & ~rst;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: random configurations per period, expected period length and
// per-channel high time computed from the counting rules, plus directed reset and enable checks.
module tb_pwm_multi;
  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int PSW   = 8;
  localparam int NRAND = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_if #(.NCH(NCH), .CW(CW), .PSW(PSW)) bus ();

  pwm_multi #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [CW-1:0]     per;
    logic [PSW-1:0]    ps;
    logic [NCH*CW-1:0] duty;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    inv;
    logic              ctr;
  } cfg_t;

  typedef struct packed {
    logic [15:0]           len;
    logic [NCH-1:0][15:0]  high;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Enumerate the counter values of one period, then count how many fall below each duty.
  function automatic exp_t model(input cfg_t c);
    exp_t e;
    int   vals[$];
    int   hit;
    int   len;
    e = '0;
    for (int v = 0; v <= int'(c.per); v++) vals.push_back(v);
    if (c.ctr && c.per != 0)
      for (int v = int'(c.per) - 1; v >= 1; v--) vals.push_back(v);
    len = vals.size() * (int'(c.ps) + 1);
    e.len = 16'(len);
    for (int ch = 0; ch < NCH; ch++) begin
      hit = 0;
      foreach (vals[j]) if (vals[j] < int'(c.duty[ch*CW +: CW])) hit++;
      hit = hit * (int'(c.ps) + 1);
      if (!c.en[ch]) e.high[ch] = c.inv[ch] ? 16'(len) : 16'd0;
      else           e.high[ch] = c.inv[ch] ? 16'(len - hit) : 16'(hit);
    end
    return e;
  endfunction

  function automatic cfg_t gen_cfg(input int idx);
    cfg_t c;
    int   sel;
    c    = '0;
    c.en = '1;
    case (idx)
      0: begin c.per = 8'd9; c.duty = {8'd255, 8'd10, 8'd3, 8'd0}; end
      1: begin c.per = 8'd3; c.ps = 8'd2; c.duty = {4{8'd2}}; end
      2: begin c.per = 8'd3; c.ps = 8'd2; c.duty = {4{8'd1}}; end
      3: begin c.per = 8'd7; c.ps = 8'd1; c.duty = {4{8'd5}}; end
      default: begin
        c.per = CW'($urandom_range(12, 0));
        c.ps  = PSW'($urandom_range(3, 0));
        for (int ch = 0; ch < NCH; ch++) begin
          sel = $urandom_range(3, 0);
          case (sel)
            0:       c.duty[ch*CW +: CW] = '0;
            1:       c.duty[ch*CW +: CW] = '1;
            2:       c.duty[ch*CW +: CW] = CW'($urandom_range(int'(c.per) + 2, 0));
            default: c.duty[ch*CW +: CW] = CW'($urandom_range(255, 0));
          endcase
        end
        c.en  = NCH'($urandom);
        c.inv = NCH'($urandom);
`ifdef PWM_CENTER_EN
        c.ctr = 1'($urandom_range(1, 0));
`endif
      end
    endcase
    return c;
  endfunction

  task automatic drive_cfg(input cfg_t c, input bit set_center);
    bus.cfg_we       = 1'b1;
    bus.cfg_period   = c.per;
    bus.cfg_prescale = c.ps;
    bus.duty_we      = 1'b1;
    bus.duty_in      = c.duty;
`ifdef PWM_CENTER_EN
    if (set_center) bus.center = c.ctr;
`else
    if (set_center) bus.cfg_we = 1'b1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.cfg_we  = 1'b0;
    bus.duty_we = 1'b0;
  endtask

  // Walk one period of `cur`, optionally writing `nxt` at a random point (or on the boundary itself).
  task automatic run_period(input cfg_t cur, input cfg_t nxt, input bit has_nxt,
                            input bit first, input bit collide);
    exp_t e;
    int   len;
    int   k;
    bit   junk;
    bit   found;
    e     = model(cur);
    len   = int'(e.len);
    k     = !has_nxt ? -1 : (collide ? len - 1 : int'($urandom_range(len - 1, 0)));
    junk  = has_nxt && (k >= 1) && ($urandom_range(1, 0) == 1);
    found = 1'b0;
    for (int cyc = 0; cyc < len + 8 && !found; cyc++) begin
      step();
      if (cyc == 0) begin
        bus.ch_en  = cur.en;
        bus.invert = cur.inv;
      end
      if (first && cyc == 1) mon_en = 1'b1;
      if (junk && cyc == k - 1) drive_cfg(gen_cfg(100), 1'b0);
      if (cyc == k) begin
        drive_cfg(nxt, 1'b1);
        sb_q.push_back(model(nxt));
      end
      if (bus.period_tick && cyc >= k) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL boundary_timeout: no period_tick within %0d clocks, expected after %0d", len + 8, len);
    end
  endtask

  task automatic load_cfg(input cfg_t c, input string name);
    bit found;
    found = 1'b0;
    drive_cfg(c, 1'b1);
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      if (cyc > 0) step();
      if (bus.period_tick) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no period_tick within 300 clocks", name);
    end
  endtask

  // Monitor: a period closes on the sample after period_tick (pwm_o lags the counter by one clock).
  initial begin : monitor
    int   len_acc;
    int   hi_acc[NCH];
    logic tick_prev;
    exp_t e;
    len_acc   = 0;
    tick_prev = 1'b0;
    foreach (hi_acc[ch]) hi_acc[ch] = 0;
    forever begin
      @(negedge clk);
      len_acc++;
      for (int ch = 0; ch < NCH; ch++) hi_acc[ch] += int'(bus.pwm_o[ch] === 1'b1);
      if (tick_prev) begin
        if (mon_en) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_period: got period of %0d clocks, expected none", len_acc);
          end else begin
            e = sb_q.pop_front();
            check("period_len", 64'(len_acc), 64'(e.len));
            for (int ch = 0; ch < NCH; ch++)
              check($sformatf("high_ch%0d", ch), 64'(hi_acc[ch]), 64'(e.high[ch]));
          end
        end
        len_acc = 0;
        foreach (hi_acc[ch]) hi_acc[ch] = 0;
      end
      tick_prev = bus.period_tick;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    cfg_t cur;
    cfg_t nxt;
    cfg_t d;
    int   errs;
    rst              = 1'b1;
    bus.cfg_we       = 1'b0;
    bus.cfg_period   = '0;
    bus.cfg_prescale = '0;
    bus.duty_we      = 1'b0;
    bus.duty_in      = '0;
    bus.ch_en        = '0;
    bus.invert       = '0;
`ifdef PWM_CENTER_EN
    bus.center       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", 64'(bus.pwm_o), 64'd0);
    check("rst_tick", 64'(bus.period_tick), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_boundary", 64'(bus.period_tick), 64'd1);

    // Cleared period/prescale make every cycle a boundary, so this write loads immediately.
    cur = gen_cfg(0);
    drive_cfg(cur, 1'b1);
    sb_q.push_back(model(cur));
    nxt = cur;
    for (int i = 1; i <= NRAND + 1; i++) begin
      if (i <= NRAND) nxt = gen_cfg(i);
      run_period(cur, nxt, i <= NRAND, i == 1, i == 3);
      cur = nxt;
    end
    step();
    step();
    mon_en = 1'b0;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    // Enable / invert timing on channel 1.
    d      = '0;
    d.per  = 8'd9;
    d.duty = {4{8'd5}};
    bus.ch_en  = '1;
    bus.invert = '0;
    step();
    load_cfg(d, "en_load");
    bus.invert = 4'b0010;
    step();
    step();
    check("inv_apply", 64'(bus.pwm_o[1]), 64'd0);
    bus.ch_en[1] = 1'b0;
    step();
    check("en_drop", 64'(bus.pwm_o[1]), 64'd1);
    check("ch0_track", 64'(bus.pwm_o[0]), 64'd1);
    bus.ch_en[1] = 1'b1;
    step();
    check("en_resume", 64'(bus.pwm_o[1]), 64'd0);
    repeat (5) step();
    check("inv_low_phase", 64'(bus.pwm_o[1]), 64'd1);
    check("ch0_low_phase", 64'(bus.pwm_o[0]), 64'd0);

    // Asynchronous reset in the middle of a long pulse.
    d.per      = 8'd255;
    d.duty     = {4{8'h80}};
    bus.invert = '0;
    bus.ch_en  = '1;
    step();
    load_cfg(d, "rst_load");
    repeat (10) step();
    check("pre_rst_high", 64'(bus.pwm_o), 64'hF);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_pwm", 64'(bus.pwm_o), 64'd0);
    check("rst_async_tick", 64'(bus.period_tick), 64'd0);
    repeat (3) step();
    check("rst_hold_tick", 64'(bus.period_tick), 64'd0);
    rst  = 1'b0;
    errs = 0;
    repeat (20) begin
      step();
      if (bus.pwm_o !== '0) errs++;
    end
    check("post_rst_quiet", 64'(errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
